axis_packet_accumulator: RTL and testbench

- AXI-stream slave that consumes packets delimited by tlast, such as those from the file-driven stream generator, and reduces each packet to one sum plus one beat count.
- Each packet result is presented on a valid/ready result port.
- Start-of-window (sow_o) and end-of-window (eow_o) strobes are produced for downstream framing logic.
- The block is the receiving end of the generator's stream in the accumulator test environment.

---
 rtl/axis_acc_pkg.sv | 26 ++
 rtl/axis_acc_adder.sv | 41 ++++
 rtl/axis_packet_accumulator.sv | 125 ++++++++++++
 tb/tb_axis_packet_accumulator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_acc_pkg.sv
// Shared types and helpers for the AXI-stream packet accumulator.
package axis_acc_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  // Widest stream supported by the shared masking helper.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} acc_state_t;

  // Zero every byte lane whose strobe bit is clear.
  function automatic logic [MAX_DATA_W-1:0] strb_mask(
    input logic [MAX_DATA_W-1:0] data,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] m;
    m = data;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      if (!strb[i]) m[i*8 +: 8] = 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_acc_adder.sv
// Combinational masked add: strobe-masked beat, zero-extended and added to the
// running sum (or loaded on the first beat). Reports carry-out as overflow.
// With AXIS_PACKET_ACCUMULATOR_SATURATE_EN defined the sum clips at all-ones,
// otherwise it wraps.
module axis_acc_adder
  import axis_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DATA_WIDTH + 16
) (
  input  logic [ACC_WIDTH-1:0]    i_acc,
  input  logic                    i_load,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [ACC_WIDTH-1:0]    o_sum,
  output logic                    o_ovf
);

  logic [DATA_WIDTH-1:0] w_masked;
  logic [ACC_WIDTH-1:0]  w_operand;
  logic [ACC_WIDTH-1:0]  w_base;
  logic [ACC_WIDTH:0]    w_full;

  assign w_masked  = DATA_WIDTH'(strb_mask(MAX_DATA_W'(i_data), MAX_STRB_W'(i_strb)));
  assign w_operand = ACC_WIDTH'(w_masked);
  // The first beat of a packet starts from zero, so it can never overflow.
  assign w_base    = i_load ? '0 : i_acc;
  assign w_full    = {1'b0, w_base} + {1'b0, w_operand};
  assign o_ovf     = w_full[ACC_WIDTH];

`ifdef AXIS_PACKET_ACCUMULATOR_SATURATE_EN
  function automatic logic [ACC_WIDTH-1:0] sat_clip(input logic [ACC_WIDTH:0] full);
    return full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
  endfunction

  assign o_sum = sat_clip(w_full);
`else
  assign o_sum = w_full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/axis_packet_accumulator.sv
// AXI-stream packet accumulator: reduces each tlast-delimited packet to a sum
// and beat count, presented on a valid/ready result port, with start/end of
// window strobes. Optional saturation: AXIS_PACKET_ACCUMULATOR_SATURATE_EN.
module axis_packet_accumulator
  import axis_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DATA_WIDTH + 16,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    m_result_valid,
  input  logic                    m_result_ready,
  output logic [ACC_WIDTH-1:0]    m_result_data,
  output logic [CNT_WIDTH-1:0]    m_result_count,
  output logic                    sow_o,
  output logic                    eow_o,
  output logic                    sat_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  acc_state_t           r_state;
  acc_state_t           w_next_state;
  logic                 w_accept;
  logic                 w_load;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_eow;

  assign w_load = (r_state == IDLE);

  axis_acc_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_adder (
    .i_acc  (r_acc),
    .i_load (w_load),
    .i_data (s_axis_tdata),
    .i_strb (s_axis_tstrb),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode, handshake outputs and start-of-window strobe.
  always_comb begin
    w_next_state   = r_state;
    s_axis_tready  = 1'b0;
    m_result_valid = 1'b0;
    sow_o          = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      IDLE: begin
        s_axis_tready = !rst;
        w_accept      = s_axis_tvalid && !rst;
        sow_o         = w_accept;
        if (w_accept) w_next_state = s_axis_tlast ? HOLD : ACCUM;
      end
      ACCUM: begin
        s_axis_tready = !rst;
        w_accept      = s_axis_tvalid && !rst;
        if (w_accept && s_axis_tlast) w_next_state = HOLD;
      end
      HOLD: begin
        m_result_valid = 1'b1;
        if (m_result_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Running sum, saturating beat counter and end-of-window pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_eow <= 1'b0;
    end else begin
      r_eow <= w_accept && s_axis_tlast;
      if (w_accept) begin
        r_acc <= w_sum;
        if (w_load)                r_cnt <= CNT_WIDTH'(1);
        else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef AXIS_PACKET_ACCUMULATOR_SATURATE_EN
  logic r_sat;

  // Sticky saturation flag for the packet in progress; restarts on its first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= w_load ? w_ovf : (r_sat | w_ovf);
    end
  end

  assign sat_o = (r_state == HOLD) && r_sat;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign sat_o        = 1'b0;
`endif

  assign m_result_data  = r_acc;
  assign m_result_count = r_cnt;
  assign eow_o          = r_eow;

endmodule

// File: tb/tb_axis_packet_accumulator.sv
// Directed testbench for axis_packet_accumulator (8-bit data, 8-bit sum,
// 4-bit counter so wrap/saturation and count limits are reachable).
module tb_axis_packet_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata;
  logic [0:0] s_axis_tstrb;
  logic       s_axis_tlast;
  logic       m_result_valid;
  logic       m_result_ready;
  logic [7:0] m_result_data;
  logic [3:0] m_result_count;
  logic       sow_o;
  logic       eow_o;
  logic       sat_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_packet_accumulator #(
    .DATA_WIDTH (8),
    .ACC_WIDTH  (8),
    .CNT_WIDTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tlast   (s_axis_tlast),
    .m_result_valid (m_result_valid),
    .m_result_ready (m_result_ready),
    .m_result_data  (m_result_data),
    .m_result_count (m_result_count),
    .sow_o          (sow_o),
    .eow_o          (eow_o),
    .sat_o          (sat_o)
  );

  // Present one beat and hold it until accepted; returns sow_o as seen in the
  // accepting cycle. Called and returns at posedge+1.
  task automatic send_beat(input logic [7:0] d, input logic [0:0] s, input logic l,
                           output logic sow_seen);
    int waited;
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    sow_seen      = 1'b0;
    waited        = 0;
    #1;
    while (!s_axis_tready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!s_axis_tready) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout tready=%0b required=1", s_axis_tready);
    end else begin
      sow_seen = sow_o;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; s_axis_tstrb = 1'b1;
    s_axis_tlast = 1'b0; m_result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready got=%0b exp=0", s_axis_tready); end
    n_tests++; if (m_result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", m_result_valid); end
    n_tests++; if (m_result_data !== 8'd0) begin n_fail++; $display("FAIL rst_data got=%0d exp=0", m_result_data); end
    n_tests++; if (m_result_count !== 4'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", m_result_count); end
    n_tests++; if (sow_o !== 1'b0 || eow_o !== 1'b0 || sat_o !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got=%0b%0b%0b exp=000", sow_o, eow_o, sat_o); end
    s_axis_tvalid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready got=%0b exp=1", s_axis_tready); end
  endtask

  task automatic test_sum_count();
    logic sow;
    m_result_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      send_beat(8'(i), 1'b1, i == 10, sow);
      n_tests++; if (sow !== (i == 1)) begin n_fail++; $display("FAIL sum_sow beat=%0d got=%0b exp=%0b", i, sow, i == 1); end
      if (i < 10) begin
        n_tests++; if (m_result_valid !== 1'b0 || eow_o !== 1'b0) begin n_fail++; $display("FAIL sum_early_valid beat=%0d got=%0b/%0b exp=0/0", i, m_result_valid, eow_o); end
      end
    end
    n_tests++; if (m_result_valid !== 1'b1) begin n_fail++; $display("FAIL sum_valid got=%0b exp=1", m_result_valid); end
    n_tests++; if (m_result_data !== 8'd55) begin n_fail++; $display("FAIL sum_data got=%0d exp=55", m_result_data); end
    n_tests++; if (m_result_count !== 4'd10) begin n_fail++; $display("FAIL sum_count got=%0d exp=10", m_result_count); end
    n_tests++; if (eow_o !== 1'b1) begin n_fail++; $display("FAIL sum_eow got=%0b exp=1", eow_o); end
    n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL sum_hold_tready got=%0b exp=0", s_axis_tready); end
    @(posedge clk); #1;
    n_tests++; if (eow_o !== 1'b0 || m_result_valid !== 1'b0) begin n_fail++; $display("FAIL sum_after eow=%0b valid=%0b exp=0/0", eow_o, m_result_valid); end
    n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL sum_after_tready got=%0b exp=1", s_axis_tready); end
  endtask

  task automatic test_single_beat();
    logic sow;
    m_result_ready = 1'b1;
    send_beat(8'hFF, 1'b1, 1'b1, sow);
    n_tests++; if (sow !== 1'b1) begin n_fail++; $display("FAIL single_sow got=%0b exp=1", sow); end
    n_tests++; if (m_result_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", m_result_valid); end
    n_tests++; if (m_result_data !== 8'd255) begin n_fail++; $display("FAIL single_data got=%0d exp=255", m_result_data); end
    n_tests++; if (m_result_count !== 4'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", m_result_count); end
    n_tests++; if (sat_o !== 1'b0) begin n_fail++; $display("FAIL single_sat got=%0b exp=0", sat_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic sow;
    m_result_ready = 1'b0;
    send_beat(8'd3, 1'b1, 1'b0, sow);
    send_beat(8'd4, 1'b1, 1'b1, sow);
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready cyc=%0d got=%0b exp=0", k, s_axis_tready); end
      n_tests++; if (m_result_valid !== 1'b1 || m_result_data !== 8'd7 || m_result_count !== 4'd2) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d valid=%0b data=%0d count=%0d exp=1/7/2", k, m_result_valid, m_result_data, m_result_count);
      end
      @(posedge clk); #1;
    end
    m_result_ready = 1'b1;
    #1;
    n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_release_same got=%0b exp=0", s_axis_tready); end
    @(posedge clk); #1;
    n_tests++; if (s_axis_tready !== 1'b1 || m_result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_next tready=%0b valid=%0b exp=1/0", s_axis_tready, m_result_valid); end
    m_result_ready = 1'b0;
    send_beat(8'd9, 1'b1, 1'b1, sow);
    n_tests++; if (m_result_data !== 8'd9 || m_result_count !== 4'd1) begin n_fail++; $display("FAIL bp_next data=%0d count=%0d exp=9/1", m_result_data, m_result_count); end
    m_result_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_strobe_gaps();
    logic sow;
    m_result_ready = 1'b1;
    send_beat(8'd5, 1'b1, 1'b0, sow);
    send_beat(8'd6, 1'b0, 1'b0, sow);
    s_axis_tdata = 8'd99;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (s_axis_tready !== 1'b1 || m_result_valid !== 1'b0) begin n_fail++; $display("FAIL gap cyc=%0d tready=%0b valid=%0b exp=1/0", k, s_axis_tready, m_result_valid); end
      @(posedge clk); #1;
    end
    send_beat(8'd7, 1'b1, 1'b1, sow);
    n_tests++; if (sow !== 1'b0) begin n_fail++; $display("FAIL strb_sow got=%0b exp=0", sow); end
    n_tests++; if (m_result_data !== 8'd12) begin n_fail++; $display("FAIL strb_data got=%0d exp=12", m_result_data); end
    n_tests++; if (m_result_count !== 4'd3) begin n_fail++; $display("FAIL strb_count got=%0d exp=3", m_result_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic sow;
    m_result_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'd10, 1'b1, 1'b0, sow);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++; if (m_result_valid !== 1'b0 || eow_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale valid=%0b eow=%0b exp=0/0", m_result_valid, eow_o); end
    n_tests++; if (m_result_data !== 8'd0 || m_result_count !== 4'd0) begin n_fail++; $display("FAIL rstmid_clear data=%0d count=%0d exp=0/0", m_result_data, m_result_count); end
    @(posedge clk); #1;
    send_beat(8'd2, 1'b1, 1'b0, sow);
    n_tests++; if (sow !== 1'b1) begin n_fail++; $display("FAIL rstmid_sow got=%0b exp=1", sow); end
    send_beat(8'd2, 1'b1, 1'b1, sow);
    n_tests++; if (m_result_data !== 8'd4 || m_result_count !== 4'd2) begin n_fail++; $display("FAIL rstmid_result data=%0d count=%0d exp=4/2", m_result_data, m_result_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic sow;
    logic [7:0] exp_data;
    logic       exp_sat;
`ifdef AXIS_PACKET_ACCUMULATOR_SATURATE_EN
    exp_data = 8'd255; exp_sat = 1'b1;
`else
    exp_data = 8'd44;  exp_sat = 1'b0;
`endif
    m_result_ready = 1'b0;
    send_beat(8'd200, 1'b1, 1'b0, sow);
    n_tests++; if (sat_o !== 1'b0) begin n_fail++; $display("FAIL ovf_sat_accum got=%0b exp=0", sat_o); end
    send_beat(8'd100, 1'b1, 1'b1, sow);
    n_tests++; if (m_result_data !== exp_data) begin n_fail++; $display("FAIL ovf_data got=%0d exp=%0d", m_result_data, exp_data); end
    n_tests++; if (sat_o !== exp_sat) begin n_fail++; $display("FAIL ovf_sat got=%0b exp=%0b", sat_o, exp_sat); end
    m_result_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (sat_o !== 1'b0) begin n_fail++; $display("FAIL ovf_sat_idle got=%0b exp=0", sat_o); end
    send_beat(8'd1, 1'b1, 1'b1, sow);
    n_tests++; if (m_result_data !== 8'd1 || sat_o !== 1'b0) begin n_fail++; $display("FAIL ovf_next data=%0d sat=%0b exp=1/0", m_result_data, sat_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_count_limit();
    logic sow;
    m_result_ready = 1'b1;
    for (int i = 1; i <= 18; i++) send_beat(8'd1, 1'b1, i == 18, sow);
    n_tests++; if (m_result_count !== 4'd15) begin n_fail++; $display("FAIL cnt_sat got=%0d exp=15", m_result_count); end
    n_tests++; if (m_result_data !== 8'd18) begin n_fail++; $display("FAIL cnt_sat_data got=%0d exp=18", m_result_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sum_count();
    test_single_beat();
    test_backpressure();
    test_strobe_gaps();
    test_reset_mid();
    test_overflow();
    test_count_limit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
